// File: rtl/msrv32_trap_controller.sv
// ---------------------------------------------------------------------------
// msrv32_trap_controller
//
// Machine-mode trap sequencer. Synchronises the asynchronous interrupt lines,
// arbitrates interrupts and exceptions by fixed priority, handles WFI sleep
// and drives the CSR update strobes, PC source select and pipeline flush.
//
// Ports
//   clk_in, reset_in           clock, synchronous active-high reset
//   *_instr_in, *_load_in, *_store_in, ecall_in, ebreak_in
//                              exception sources from the decoder
//   mret_in, wfi_in            decoded SYSTEM instructions
//   e_irq_in, t_irq_in, s_irq_in, plat_irq_in
//                              asynchronous level interrupt requests
//   mie_in, meie_in, mtie_in, msie_in, plat_ie_in
//                              CSR enable bits
//   mtvec_mode_in              1 = vectored trap vector
//   i_or_e_out, cause_out      latched trap type and cause
//   trap_offset_out            byte offset added to the mtvec base
//   set_epc_out, set_cause_out, mie_clear_out, mie_set_out, instret_inc_out
//                              CSR strobes
//   pc_src_out                 00 BOOT, 01 EPC, 10 TRAP, 11 NEXT
//   flush_out, stall_out       pipeline flush / hold while sleeping
//   trap_taken_out             combinational trap request
// ---------------------------------------------------------------------------
module msrv32_trap_controller #(
    parameter int N_IRQ       = 4,
    parameter int CAUSE_W     = 5,
    parameter int SYNC_STAGES = 2,
    parameter int VECTORED_EN = 1
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               illegal_instr_in,
    input  logic               misaligned_instr_in,
    input  logic               misaligned_load_in,
    input  logic               misaligned_store_in,
    input  logic               ecall_in,
    input  logic               ebreak_in,
    input  logic               mret_in,
    input  logic               wfi_in,
    input  logic               e_irq_in,
    input  logic               t_irq_in,
    input  logic               s_irq_in,
    input  logic [N_IRQ-1:0]   plat_irq_in,
    input  logic               mie_in,
    input  logic               meie_in,
    input  logic               mtie_in,
    input  logic               msie_in,
    input  logic [N_IRQ-1:0]   plat_ie_in,
    input  logic               mtvec_mode_in,
    output logic               i_or_e_out,
    output logic [CAUSE_W-1:0] cause_out,
    output logic [CAUSE_W+1:0] trap_offset_out,
    output logic               set_epc_out,
    output logic               set_cause_out,
    output logic               mie_clear_out,
    output logic               mie_set_out,
    output logic               instret_inc_out,
    output logic [1:0]         pc_src_out,
    output logic               flush_out,
    output logic               stall_out,
    output logic               trap_taken_out
);

    localparam int IRQ_W = N_IRQ + 3;

    localparam logic [4:0] ST_RESET       = 5'b00001;
    localparam logic [4:0] ST_OPERATING   = 5'b00010;
    localparam logic [4:0] ST_TRAP_TAKEN  = 5'b00100;
    localparam logic [4:0] ST_TRAP_RETURN = 5'b01000;
    localparam logic [4:0] ST_WFI_SLEEP   = 5'b10000;

    logic [4:0]         state_q, state_d;
    logic [IRQ_W-1:0]   sync_q [SYNC_STAGES];
    logic [IRQ_W-1:0]   irq_sync;
    logic [N_IRQ-1:0]   plat_pend;
    logic               eip, tip, sip, ip, exc, irq_take;
    logic               is_op, is_wfi;
    logic [CAUSE_W-1:0] trap_cause;
    logic               trap_is_irq;

    // Synchroniser chain; bit order {plat, s, t, e}.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {plat_irq_in, s_irq_in, t_irq_in, e_irq_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign irq_sync  = sync_q[SYNC_STAGES-1];
    assign eip       = meie_in & irq_sync[0];
    assign tip       = mtie_in & irq_sync[1];
    assign sip       = msie_in & irq_sync[2];
    assign plat_pend = irq_sync[3 +: N_IRQ] & plat_ie_in;
    assign ip        = eip | tip | sip | (|plat_pend);
    assign irq_take  = mie_in & ip;
    assign exc       = illegal_instr_in | misaligned_instr_in | misaligned_load_in |
                       misaligned_store_in | ecall_in | ebreak_in;

    assign is_op  = (state_q == ST_OPERATING);
    assign is_wfi = (state_q == ST_WFI_SLEEP);

    // While sleeping only enabled interrupts can wake into a trap.
    assign trap_taken_out = (is_op & (exc | irq_take)) | (is_wfi & irq_take);

    // Fixed-priority cause selection: interrupts beat exceptions.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        trap_cause  = '0;
        trap_is_irq = 1'b0;
        if (irq_take) begin
            trap_is_irq = 1'b1;
            if (eip)      trap_cause = CAUSE_W'(11);
            else if (sip) trap_cause = CAUSE_W'(3);
            else if (tip) trap_cause = CAUSE_W'(7);
            else begin
                // Scan downwards so the lowest pending line is the last write.
                for (int k = N_IRQ - 1; k >= 0; k--) begin
                    if (plat_pend[k]) trap_cause = CAUSE_W'(16 + k);
                end
            end
        end else if (misaligned_instr_in) trap_cause = CAUSE_W'(0);
        else if (illegal_instr_in)        trap_cause = CAUSE_W'(2);
        else if (ebreak_in)               trap_cause = CAUSE_W'(3);
        else if (ecall_in)                trap_cause = CAUSE_W'(11);
        else if (misaligned_load_in)      trap_cause = CAUSE_W'(4);
        else if (misaligned_store_in)     trap_cause = CAUSE_W'(6);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            cause_out  <= '0;
            i_or_e_out <= 1'b0;
        end else if (trap_taken_out) begin
            cause_out  <= trap_cause;
            i_or_e_out <= trap_is_irq;
        end
    end

    always_comb begin
        state_d = ST_OPERATING;
        case (state_q)
            ST_RESET:     state_d = ST_OPERATING;
            ST_OPERATING: begin
                if (trap_taken_out) state_d = ST_TRAP_TAKEN;
                else if (mret_in)   state_d = ST_TRAP_RETURN;
                else if (wfi_in)    state_d = ST_WFI_SLEEP;
                else                state_d = ST_OPERATING;
            end
            ST_WFI_SLEEP: begin
                if (irq_take)  state_d = ST_TRAP_TAKEN;
                else if (ip)   state_d = ST_OPERATING;
                else           state_d = ST_WFI_SLEEP;
            end
            default:      state_d = ST_OPERATING;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) state_q <= ST_RESET;
        else          state_q <= state_d;
    end

    // Output decode; unknown encodings behave like OPERATING.
    always_comb begin
        pc_src_out      = 2'b11;
        flush_out       = 1'b0;
        stall_out       = 1'b0;
        set_epc_out     = 1'b0;
        set_cause_out   = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        instret_inc_out = 1'b1;
        case (state_q)
            ST_RESET: begin
                pc_src_out      = 2'b00;
                flush_out       = 1'b1;
                instret_inc_out = 1'b0;
            end
            ST_TRAP_TAKEN: begin
                pc_src_out      = 2'b10;
                flush_out       = 1'b1;
                set_epc_out     = 1'b1;
                set_cause_out   = 1'b1;
                mie_clear_out   = 1'b1;
                instret_inc_out = 1'b0;
            end
            ST_TRAP_RETURN: begin
                pc_src_out      = 2'b01;
                flush_out       = 1'b1;
                mie_set_out     = 1'b1;
                instret_inc_out = 1'b0;
            end
            ST_WFI_SLEEP: begin
                stall_out       = 1'b1;
                instret_inc_out = 1'b0;
            end
            default: ;
        endcase
    end

    assign trap_offset_out = ((VECTORED_EN != 0) && mtvec_mode_in && i_or_e_out) ?
                             {cause_out, 2'b00} : '0;

endmodule

// File: tb/tb_msrv32_trap_controller.sv
module tb_msrv32_trap_controller;

    localparam int N_IRQ       = 4;
    localparam int CAUSE_W     = 5;
    localparam int SYNC_STAGES = 2;

    // Control vector order: {pc_src[1:0], flush, stall, set_epc, set_cause, mie_clear, mie_set, instret}
    localparam logic [8:0] C_RESET = 9'b00_1_0_000_0_0;
    localparam logic [8:0] C_OP    = 9'b11_0_0_000_0_1;
    localparam logic [8:0] C_TT    = 9'b10_1_0_111_0_0;
    localparam logic [8:0] C_TR    = 9'b01_1_0_000_1_0;
    localparam logic [8:0] C_WFI   = 9'b11_0_1_000_0_0;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic reset_in = 1'b1;
    logic illegal_instr_in = 0, misaligned_instr_in = 0, misaligned_load_in = 0, misaligned_store_in = 0;
    logic ecall_in = 0, ebreak_in = 0, mret_in = 0, wfi_in = 0;
    logic e_irq_in = 0, t_irq_in = 0, s_irq_in = 0;
    logic [N_IRQ-1:0] plat_irq_in = '0, plat_ie_in = '0;
    logic mie_in = 0, meie_in = 0, mtie_in = 0, msie_in = 0, mtvec_mode_in = 1;

    logic               i_or_e_out, set_epc_out, set_cause_out, mie_clear_out, mie_set_out;
    logic               instret_inc_out, flush_out, stall_out, trap_taken_out;
    logic [CAUSE_W-1:0] cause_out;
    logic [CAUSE_W+1:0] trap_offset_out;
    logic [1:0]         pc_src_out;

    msrv32_trap_controller #(
        .N_IRQ(N_IRQ), .CAUSE_W(CAUSE_W), .SYNC_STAGES(SYNC_STAGES), .VECTORED_EN(1)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .illegal_instr_in(illegal_instr_in), .misaligned_instr_in(misaligned_instr_in),
        .misaligned_load_in(misaligned_load_in), .misaligned_store_in(misaligned_store_in),
        .ecall_in(ecall_in), .ebreak_in(ebreak_in), .mret_in(mret_in), .wfi_in(wfi_in),
        .e_irq_in(e_irq_in), .t_irq_in(t_irq_in), .s_irq_in(s_irq_in), .plat_irq_in(plat_irq_in),
        .mie_in(mie_in), .meie_in(meie_in), .mtie_in(mtie_in), .msie_in(msie_in),
        .plat_ie_in(plat_ie_in), .mtvec_mode_in(mtvec_mode_in),
        .i_or_e_out(i_or_e_out), .cause_out(cause_out), .trap_offset_out(trap_offset_out),
        .set_epc_out(set_epc_out), .set_cause_out(set_cause_out), .mie_clear_out(mie_clear_out),
        .mie_set_out(mie_set_out), .instret_inc_out(instret_inc_out), .pc_src_out(pc_src_out),
        .flush_out(flush_out), .stall_out(stall_out), .trap_taken_out(trap_taken_out)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef enum {M_RESET, M_OP, M_TT, M_TR, M_WFI} mstate_t;
    mstate_t            m_state = M_RESET;
    logic [N_IRQ+2:0]   m_hist[$];   // raw IRQ samples, newest first: {plat, s, t, e}
    int                 m_cause = 0;
    bit                 m_irq = 0;

    // Highest-priority enabled pending interrupt as seen after the synchroniser, or -1.
    function automatic int m_irq_cause();
        logic [N_IRQ+2:0] s;
        s = m_hist[SYNC_STAGES-1];
        if (meie_in && s[0]) return 11;
        if (msie_in && s[2]) return 3;
        if (mtie_in && s[1]) return 7;
        for (int k = 0; k < N_IRQ; k++)
            if (s[3+k] && plat_ie_in[k]) return 16 + k;
        return -1;
    endfunction

    function automatic int m_exc_cause();
        if (misaligned_instr_in) return 0;
        if (illegal_instr_in)    return 2;
        if (ebreak_in)           return 3;
        if (ecall_in)            return 11;
        if (misaligned_load_in)  return 4;
        if (misaligned_store_in) return 6;
        return -1;
    endfunction

    function automatic bit m_trap();
        bit take_irq;
        take_irq = mie_in && (m_irq_cause() >= 0);
        if (m_state == M_OP)  return take_irq || (m_exc_cause() >= 0);
        if (m_state == M_WFI) return take_irq;
        return 1'b0;
    endfunction

    function automatic logic [8:0] m_ctrl();
        case (m_state)
            M_RESET: return C_RESET;
            M_TT:    return C_TT;
            M_TR:    return C_TR;
            M_WFI:   return C_WFI;
            default: return C_OP;
        endcase
    endfunction

    function automatic logic [8:0] dut_ctrl();
        return {pc_src_out, flush_out, stall_out, set_epc_out, set_cause_out,
                mie_clear_out, mie_set_out, instret_inc_out};
    endfunction

    task automatic model_advance();
        int  ic;
        bit  take, tr;
        if (reset_in) begin
            m_state = M_RESET;
            m_cause = 0;
            m_irq   = 0;
            m_hist.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back('0);
        end else begin
            ic   = m_irq_cause();
            take = mie_in && (ic >= 0);
            tr   = m_trap();
            if (tr) begin
                m_irq   = take;
                m_cause = take ? ic : m_exc_cause();
            end
            case (m_state)
                M_OP:    m_state = tr ? M_TT : mret_in ? M_TR : wfi_in ? M_WFI : M_OP;
                M_WFI:   m_state = take ? M_TT : (ic >= 0) ? M_OP : M_WFI;
                default: m_state = M_OP;
            endcase
            m_hist.push_front({plat_irq_in, s_irq_in, t_irq_in, e_irq_in});
            void'(m_hist.pop_back());
        end
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_inputs();
        {illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in} = '0;
        {ecall_in, ebreak_in, mret_in, wfi_in, e_irq_in, t_irq_in, s_irq_in} = '0;
        {mie_in, meie_in, mtie_in, msie_in} = '0;
        plat_irq_in = '0;
        plat_ie_in  = '0;
        mtvec_mode_in = 1'b1;
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        reset_in = 1'b1;
        tick(); tick();
        checks++; if (dut_ctrl() !== C_RESET) begin errors++; $display("FAIL reset_hold_ctrl: got %b expected %b", dut_ctrl(), C_RESET); end
        checks++; if (cause_out !== 5'd0 || i_or_e_out !== 1'b0) begin errors++; $display("FAIL reset_cause: got %0d/%b expected 0/0", cause_out, i_or_e_out); end
        reset_in = 1'b0;
        #1;
        checks++; if (dut_ctrl() !== C_RESET) begin errors++; $display("FAIL reset_release_ctrl: got %b expected %b", dut_ctrl(), C_RESET); end
        tick();
        checks++; if (dut_ctrl() !== C_OP) begin errors++; $display("FAIL reset_to_op: got %b expected %b", dut_ctrl(), C_OP); end
    endtask

    task automatic test_plat_irq();
        mie_in = 1; plat_ie_in = 4'b0100; plat_irq_in = 4'b0100;
        #1;
        checks++; if (trap_taken_out !== 1'b0) begin errors++; $display("FAIL plat_unsynced: got %b expected 0", trap_taken_out); end
        tick();
        checks++; if (trap_taken_out !== 1'b0) begin errors++; $display("FAIL plat_stage1: got %b expected 0", trap_taken_out); end
        tick();
        checks++; if (trap_taken_out !== 1'b1) begin errors++; $display("FAIL plat_synced: got %b expected 1", trap_taken_out); end
        tick();
        checks++; if (cause_out !== 5'd18 || i_or_e_out !== 1'b1 || trap_offset_out !== 7'd72)
            begin errors++; $display("FAIL plat_cause: got %0d/%b/%0d expected 18/1/72", cause_out, i_or_e_out, trap_offset_out); end
        checks++; if (dut_ctrl() !== C_TT) begin errors++; $display("FAIL plat_tt_ctrl: got %b expected %b", dut_ctrl(), C_TT); end
        clear_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_priority();
        meie_in = 1; mtie_in = 1; e_irq_in = 1; t_irq_in = 1;
        tick(); tick();
        mie_in = 1; illegal_instr_in = 1;
        #1;
        checks++; if (trap_taken_out !== 1'b1) begin errors++; $display("FAIL prio_trap: got %b expected 1", trap_taken_out); end
        tick();
        checks++; if (cause_out !== 5'd11 || i_or_e_out !== 1'b1 || trap_offset_out !== 7'd44)
            begin errors++; $display("FAIL prio_irq: got %0d/%b/%0d expected 11/1/44", cause_out, i_or_e_out, trap_offset_out); end
        mie_in = 0;
        tick(); tick();
        checks++; if (cause_out !== 5'd2 || i_or_e_out !== 1'b0 || trap_offset_out !== 7'd0)
            begin errors++; $display("FAIL prio_exc: got %0d/%b/%0d expected 2/0/0", cause_out, i_or_e_out, trap_offset_out); end
        clear_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_wfi_sleep();
        wfi_in = 1;
        tick();
        wfi_in = 0;
        for (int i = 0; i < 10; i++) begin
            checks++; if (dut_ctrl() !== C_WFI) begin errors++; $display("FAIL wfi_idle_%0d: got %b expected %b", i, dut_ctrl(), C_WFI); end
            tick();
        end
        msie_in = 1; s_irq_in = 1;
        tick(); tick();
        checks++; if (trap_taken_out !== 1'b0 || dut_ctrl() !== C_WFI)
            begin errors++; $display("FAIL wfi_wake_pre: got %b/%b expected 0/%b", trap_taken_out, dut_ctrl(), C_WFI); end
        tick();
        checks++; if (dut_ctrl() !== C_OP) begin errors++; $display("FAIL wfi_wake_op: got %b expected %b", dut_ctrl(), C_OP); end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_wfi_trap();
        wfi_in = 1;
        tick();
        wfi_in = 0; mie_in = 1; mtie_in = 1; t_irq_in = 1;
        tick(); tick();
        checks++; if (trap_taken_out !== 1'b1) begin errors++; $display("FAIL wfi_trap_req: got %b expected 1", trap_taken_out); end
        tick();
        checks++; if (dut_ctrl() !== C_TT || cause_out !== 5'd7)
            begin errors++; $display("FAIL wfi_trap_tt: got %b/%0d expected %b/7", dut_ctrl(), cause_out, C_TT); end
        mie_in = 0; t_irq_in = 0;
        tick();
        checks++; if (dut_ctrl() !== C_OP) begin errors++; $display("FAIL wfi_trap_pulse: got %b expected %b", dut_ctrl(), C_OP); end
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        // WFI decoded while an enabled interrupt is already pending: the trap wins.
        mtie_in = 1; t_irq_in = 1;
        tick(); tick();
        mie_in = 1; wfi_in = 1;
        #1;
        checks++; if (trap_taken_out !== 1'b1) begin errors++; $display("FAIL wfi_pending_req: got %b expected 1", trap_taken_out); end
        tick();
        checks++; if (dut_ctrl() !== C_TT) begin errors++; $display("FAIL wfi_pending_tt: got %b expected %b", dut_ctrl(), C_TT); end
        clear_inputs();
        tick(); tick(); tick();
    endtask

    task automatic test_mret_reset();
        mret_in = 1;
        tick();
        checks++; if (dut_ctrl() !== C_TR) begin errors++; $display("FAIL mret_tr: got %b expected %b", dut_ctrl(), C_TR); end
        mret_in = 0;
        tick();
        checks++; if (dut_ctrl() !== C_OP) begin errors++; $display("FAIL mret_back: got %b expected %b", dut_ctrl(), C_OP); end
        ecall_in = 1;
        tick();
        checks++; if (dut_ctrl() !== C_TT || cause_out !== 5'd11 || i_or_e_out !== 1'b0)
            begin errors++; $display("FAIL ecall_tt: got %b/%0d/%b expected %b/11/0", dut_ctrl(), cause_out, i_or_e_out, C_TT); end
        ecall_in = 0; reset_in = 1;
        tick();
        checks++; if (dut_ctrl() !== C_RESET || cause_out !== 5'd0)
            begin errors++; $display("FAIL tt_reset: got %b/%0d expected %b/0", dut_ctrl(), cause_out, C_RESET); end
        reset_in = 0;
        tick();
        checks++; if (dut_ctrl() !== C_OP) begin errors++; $display("FAIL tt_reset_op: got %b expected %b", dut_ctrl(), C_OP); end
    endtask

    task automatic test_random();
        logic [22:0] exp_v, got_v;
        logic [6:0]  exp_off;
        for (int n = 0; n < 3000; n++) begin
            reset_in            = ($urandom_range(0, 249) == 0);
            misaligned_instr_in = ($urandom_range(0, 31) == 0);
            illegal_instr_in    = ($urandom_range(0, 31) == 0);
            ebreak_in           = ($urandom_range(0, 31) == 0);
            ecall_in            = ($urandom_range(0, 31) == 0);
            misaligned_load_in  = ($urandom_range(0, 31) == 0);
            misaligned_store_in = ($urandom_range(0, 31) == 0);
            mret_in             = ($urandom_range(0, 9) == 0);
            wfi_in              = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) e_irq_in = ~e_irq_in;
            if ($urandom_range(0, 7) == 0) t_irq_in = ~t_irq_in;
            if ($urandom_range(0, 7) == 0) s_irq_in = ~s_irq_in;
            for (int k = 0; k < N_IRQ; k++)
                if ($urandom_range(0, 9) == 0) plat_irq_in[k] = ~plat_irq_in[k];
            mie_in        = $urandom_range(0, 1);
            meie_in       = ($urandom_range(0, 3) != 0);
            mtie_in       = ($urandom_range(0, 3) != 0);
            msie_in       = ($urandom_range(0, 3) != 0);
            plat_ie_in    = N_IRQ'($urandom);
            mtvec_mode_in = $urandom_range(0, 1);
            #1;
            exp_off = (mtvec_mode_in && m_irq) ? 7'(m_cause * 4) : 7'd0;
            exp_v = {m_trap(), m_ctrl(), CAUSE_W'(m_cause), m_irq, exp_off};
            got_v = {trap_taken_out, dut_ctrl(), cause_out, i_or_e_out, trap_offset_out};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_%0d: got trap=%b ctrl=%b cause=%0d irq=%b off=%0d expected trap=%b ctrl=%b cause=%0d irq=%b off=%0d",
                         n, got_v[22], got_v[21:13], got_v[12:8], got_v[7], got_v[6:0],
                         exp_v[22], exp_v[21:13], exp_v[12:8], exp_v[7], exp_v[6:0]);
            end
            tick();
        end
        clear_inputs();
        reset_in = 0;
    endtask

    initial begin
        for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back('0);
        test_reset();
        test_plat_irq();
        test_priority();
        test_wfi_sleep();
        test_wfi_trap();
        test_back_to_back();
        test_mret_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
